motor_rodadas_param: RTL and testbench
======================================

// Module: motor_rodadas_param
// PURPOSE
//  Parametrised round engine for the flag-guessing game: sequences N_RODADAS plays, shows each flag LED,
//  waits for a one-hot button press under a difficulty-dependent timeout, then scores and shows the result.
//  Integrates FSM + datapath (timers, play/score counters, press edge detect). Flag pattern comes from an
//  external sync ROM (1-cycle read latency). Sits between board I/O and the ROM.
// PARAMETERS
//  N_BOTOES    8     buttons/LEDs; flag patterns are N_BOTOES bits, one-hot
//  N_RODADAS   8     plays per game at hard difficulty
//  RODADAS_FAC 4     plays per game at easy difficulty (1..N_RODADAS)
//  W_TMR       13    width of all timers
//  T_LED       2000  cycles flag is shown
//  T_RES       2000  cycles result is shown
//  T_TO_FAC    5000  response timeout, easy (dificuldade=0)
//  T_TO_DIF    3000  response timeout, hard (dificuldade=1)
//  (derived) AW=$clog2(N_RODADAS), SW=$clog2(N_RODADAS+1); all T_* < 2**W_TMR
// PORTS
//  clock        in   1         system clock, all logic on rising edge
//  reset        in   1         synchronous, active-high; returns block to OCIOSO
//  iniciar      in   1         start pulse, honoured only in OCIOSO/FIM
//  dificuldade  in   1         0=easy, 1=hard; latched when iniciar accepted
//  botoes       in   N_BOTOES  raw (already debounced) buttons
//  mem_endereco out  AW        ROM address = current play index
//  mem_dado     in   N_BOTOES  ROM data, valid 1 cycle after mem_endereco changes
//  leds         out  N_BOTOES  LED drive
//  score        out  SW        correct plays this game
//  acertou      out  1         1 during RESULTADO if last play correct
//  deu_timeout  out  1         1 during RESULTADO if last play timed out
//  pronto       out  1         1 in FIM
//  db_jogada    out  N_BOTOES  registered press
//  db_estado    out  4         FSM state code (encoding below)
// BEHAVIOUR
//  Reset: state OCIOSO(0); leds=0, score=0, acertou=0, deu_timeout=0, pronto=0, db_jogada=0,
//   mem_endereco=0, all timers 0, latched difficulty=0.
//  States: OCIOSO0 PREPARA1 BUSCA2 MOSTRA3 ESPERA4 REGISTRA5 COMPARA6 RESULTADO7 PROXIMA8 FIM9.
//  OCIOSO -iniciar-> PREPARA: clear score/play idx/db_jogada, latch dificuldade, limit L=N_RODADAS|RODADAS_FAC.
//  PREPARA -> BUSCA (1 cycle, ROM latency) -> MOSTRA: leds=mem_dado for exactly T_LED cycles -> ESPERA.
//  ESPERA: leds=0; timeout timer counts; press detector armed only after botoes==0 seen in ESPERA
//   (button held from MOSTRA never registers). Press = first cycle armed and |botoes.
//   Press -> REGISTRA (db_jogada<=botoes) -> COMPARA. Timer reaches T_TO_x-1 with no press -> RESULTADO
//   with deu_timeout=1, acertou=0. Press and timeout in same cycle: press wins.
//  COMPARA: correct iff db_jogada==mem_dado (multi-button press is wrong); correct -> score+1, saturating
//   at N_RODADAS. -> RESULTADO.
//  RESULTADO: T_RES cycles; leds=mem_dado if correct, else all-ones; acertou/deu_timeout held, then cleared.
//  PROXIMA: idx==L-1 -> FIM, else idx+1 -> BUSCA. Play idx never wraps.
//  FIM: pronto=1, leds=0, score held until next iniciar (-> PREPARA, score cleared).
//  iniciar outside OCIOSO/FIM ignored; dificuldade changes mid-game ignored.
//  All timers cleared on entry to the state using them; reset in any state -> OCIOSO next cycle.
// TESTING (bench: T_LED=4, T_RES=3, T_TO_FAC=10, T_TO_DIF=6, N_RODADAS=4, RODADAS_FAC=2)
//  1 hard, ROM {01,02,04,08}, correct one-hot press each play -> score=4, pronto=1, 4 MOSTRA windows of 4 cycles.
//  2 easy, no presses -> 2 plays, each RESULTADO deu_timeout=1 after 10 ESPERA cycles, leds=FF, score=0.
//  3 botoes=8'h03 at play 0 (ROM 01) -> acertou=0, db_jogada=03, score unchanged.
//  4 button held through MOSTRA into ESPERA -> no register until release then repress; press on timeout cycle -> scored.
//  5 reset asserted in ESPERA of play 2 -> next cycle db_estado=0, score=0, leds=0; iniciar during play ignored.
//  6 restart from FIM with dificuldade toggled -> score cleared, new play limit applied.

Source files
------------

// File: rtl/motor_rodadas_param_if.sv
// rtl/motor_rodadas_param_if.sv - flag ROM read bus between round engine and pattern ROM
// The engine drives the play index as address; the ROM answers one cycle later.
interface motor_rodadas_param_if #(
    parameter int N_BOTOES = 8,
    parameter int AW       = 3
);
    logic [AW-1:0]       mem_endereco;
    logic [N_BOTOES-1:0] mem_dado;

    modport master (
        output mem_endereco,
        input  mem_dado
    );

    modport slave (
        input  mem_endereco,
        output mem_dado
    );
endinterface

// File: rtl/motor_rodadas_param.sv
// rtl/motor_rodadas_param.sv - round engine for the flag-guessing game
// Sequences plays, shows each flag, times the one-hot answer, scores and shows the result.
module motor_rodadas_param #(
    parameter int N_BOTOES    = 8,
    parameter int N_RODADAS   = 8,
    parameter int RODADAS_FAC = 4,
    parameter int W_TMR       = 13,
    parameter int T_LED       = 2000,
    parameter int T_RES       = 2000,
    parameter int T_TO_FAC    = 5000,
    parameter int T_TO_DIF    = 3000,
    localparam int AW = (N_RODADAS > 1) ? $clog2(N_RODADAS) : 1,
    localparam int SW = $clog2(N_RODADAS + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                dificuldade,
    input  logic [N_BOTOES-1:0] botoes,
    motor_rodadas_param_if.master mem,
    output logic [N_BOTOES-1:0] leds,
    output logic [SW-1:0]       score,
    output logic                acertou,
    output logic                deu_timeout,
    output logic                pronto,
    output logic [N_BOTOES-1:0] db_jogada,
    output logic [3:0]          db_estado
);
    localparam logic [3:0] OCIOSO    = 4'd0;
    localparam logic [3:0] PREPARA   = 4'd1;
    localparam logic [3:0] BUSCA     = 4'd2;
    localparam logic [3:0] MOSTRA    = 4'd3;
    localparam logic [3:0] ESPERA    = 4'd4;
    localparam logic [3:0] REGISTRA  = 4'd5;
    localparam logic [3:0] COMPARA   = 4'd6;
    localparam logic [3:0] RESULTADO = 4'd7;
    localparam logic [3:0] PROXIMA   = 4'd8;
    localparam logic [3:0] FIM       = 4'd9;

    localparam logic [W_TMR-1:0] LED_END    = W_TMR'(T_LED - 1);
    localparam logic [W_TMR-1:0] RES_END    = W_TMR'(T_RES - 1);
    localparam logic [W_TMR-1:0] TO_FAC_END = W_TMR'(T_TO_FAC - 1);
    localparam logic [W_TMR-1:0] TO_DIF_END = W_TMR'(T_TO_DIF - 1);
    localparam logic [AW-1:0]    LAST_DIF   = AW'(N_RODADAS - 1);
    localparam logic [AW-1:0]    LAST_FAC   = AW'(RODADAS_FAC - 1);
    localparam logic [SW-1:0]    SCORE_MAX  = SW'(N_RODADAS);

    logic [3:0]          state_q, state_d;
    logic [W_TMR-1:0]    tmr_q, tmr_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [SW-1:0]       score_q, score_d;
    logic [N_BOTOES-1:0] jog_q, jog_d;
    logic                dif_q, dif_d;
    logic                armed_q, armed_d;
    logic                acertou_q, acertou_d;
    logic                timeout_q, timeout_d;

    logic [W_TMR-1:0]    to_end;
    logic [AW-1:0]       idx_last;
    logic                correto;

    assign to_end   = dif_q ? TO_DIF_END : TO_FAC_END;
    assign idx_last = dif_q ? LAST_DIF : LAST_FAC;
    assign correto  = (jog_q == mem.mem_dado);

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        idx_d     = idx_q;
        score_d   = score_q;
        jog_d     = jog_q;
        dif_d     = dif_q;
        armed_d   = armed_q;
        acertou_d = acertou_q;
        timeout_d = timeout_q;
        case (state_q)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    state_d = PREPARA;
                    score_d = '0;
                    idx_d   = '0;
                    jog_d   = '0;
                    dif_d   = dificuldade;
                end
            end
            PREPARA: state_d = BUSCA;
            BUSCA: begin
                state_d = MOSTRA;
                tmr_d   = '0;
            end
            MOSTRA: begin
                if (tmr_q == LED_END) begin
                    state_d = ESPERA;
                    tmr_d   = '0;
                    armed_d = 1'b0;
                end else begin
                    tmr_d = tmr_q + W_TMR'(1);
                end
            end
            ESPERA: begin
                // A press outranks a timeout landing on the same cycle.
                if (armed_q && (|botoes)) begin
                    state_d = REGISTRA;
                    jog_d   = botoes;
                end else if (tmr_q == to_end) begin
                    state_d   = RESULTADO;
                    tmr_d     = '0;
                    acertou_d = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + W_TMR'(1);
                    if (!armed_q && (botoes == '0)) begin
                        armed_d = 1'b1;
                    end
                end
            end
            REGISTRA: state_d = COMPARA;
            COMPARA: begin
                state_d   = RESULTADO;
                tmr_d     = '0;
                acertou_d = correto;
                timeout_d = 1'b0;
                if (correto && (score_q != SCORE_MAX)) begin
                    score_d = score_q + SW'(1);
                end
            end
            RESULTADO: begin
                if (tmr_q == RES_END) begin
                    state_d   = PROXIMA;
                    tmr_d     = '0;
                    acertou_d = 1'b0;
                    timeout_d = 1'b0;
                end else begin
                    tmr_d = tmr_q + W_TMR'(1);
                end
            end
            PROXIMA: begin
                if (idx_q == idx_last) begin
                    state_d = FIM;
                end else begin
                    state_d = BUSCA;
                    idx_d   = idx_q + AW'(1);
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= OCIOSO;
            tmr_q     <= '0;
            idx_q     <= '0;
            score_q   <= '0;
            jog_q     <= '0;
            dif_q     <= 1'b0;
            armed_q   <= 1'b0;
            acertou_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            idx_q     <= idx_d;
            score_q   <= score_d;
            jog_q     <= jog_d;
            dif_q     <= dif_d;
            armed_q   <= armed_d;
            acertou_q <= acertou_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        case (state_q)
            MOSTRA:    leds = mem.mem_dado;
            RESULTADO: leds = acertou_q ? mem.mem_dado : '1;
            default:   leds = '0;
        endcase
    end

    assign mem.mem_endereco = idx_q;
    assign score            = score_q;
    assign acertou          = acertou_q;
    assign deu_timeout      = timeout_q;
    assign pronto           = (state_q == FIM);
    assign db_jogada        = jog_q;
    assign db_estado        = state_q;
endmodule

// File: tb/tb_motor_rodadas_param.sv
// tb/tb_motor_rodadas_param.sv - scoreboarded game-table bench for motor_rodadas_param
module tb_motor_rodadas_param;
    localparam int T_LED = 4;
    localparam int T_RES = 3;
    localparam int T_FAC = 10;
    localparam int T_DIF = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       dificuldade = 1'b0;
    logic [7:0] botoes = 8'h00;
    logic [7:0] leds;
    logic [2:0] score;
    logic       acertou, deu_timeout, pronto;
    logic [7:0] db_jogada;
    logic [3:0] db_estado;

    always #5 clock = ~clock;

    motor_rodadas_param_if #(.N_BOTOES(8), .AW(2)) bus ();

    motor_rodadas_param #(
        .N_BOTOES(8), .N_RODADAS(4), .RODADAS_FAC(2), .W_TMR(13),
        .T_LED(T_LED), .T_RES(T_RES), .T_TO_FAC(T_FAC), .T_TO_DIF(T_DIF)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .dificuldade(dificuldade),
        .botoes(botoes), .mem(bus), .leds(leds), .score(score), .acertou(acertou),
        .deu_timeout(deu_timeout), .pronto(pronto), .db_jogada(db_jogada), .db_estado(db_estado)
    );

    logic [3:0][7:0] rom;
    always @(posedge clock) bus.mem_dado <= rom[bus.mem_endereco];

    typedef struct {
        logic            dif;
        logic [3:0][7:0] rom;
        logic [3:0][7:0] press;
        int              exp_score;
        int              exp_plays;
    } game_t;

    typedef struct {
        logic       acertou;
        logic       to;
        logic [7:0] leds;
        logic [7:0] jog;
        int         score;
        int         esp;
    } exp_t;

    exp_t sb[$];
    game_t games[4];

    int checks = 0;
    int errors = 0;
    int plays = 0;
    int exp_score = 0;
    logic [7:0] exp_jog = 8'h00;
    logic cur_dif = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget);
        int n = 0;
        while (db_estado !== s && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (db_estado !== s) begin
            checks++;
            errors++;
            $display("FAIL wait_state: state %0d never reached, stuck at %0d", s, db_estado);
        end
    endtask

    // Monitor: window lengths and scoreboard pop on every RESULTADO entry.
    logic [3:0] prev_st = 4'd0;
    int esp_cnt = 0;
    int mos_cnt = 0;
    always @(negedge clock) begin
        exp_t e;
        if (db_estado == 4'd4) esp_cnt = (prev_st == 4'd4) ? esp_cnt + 1 : 1;
        if (db_estado == 4'd3) mos_cnt = (prev_st == 4'd3) ? mos_cnt + 1 : 1;
        if (prev_st == 4'd3 && db_estado != 4'd3) chk("mostra_len", mos_cnt, T_LED);
        if (db_estado == 4'd7 && prev_st != 4'd7) begin
            plays++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: unexpected RESULTADO at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("res_acertou", acertou, e.acertou);
                chk("res_timeout", deu_timeout, e.to);
                chk("res_leds", leds, e.leds);
                chk("res_jogada", db_jogada, e.jog);
                chk("res_score", score, e.score);
                if (e.esp != 0) chk("espera_len", (prev_st == 4'd4) ? esp_cnt : 0, e.esp);
            end
        end
        prev_st = db_estado;
    end

    function automatic exp_t make_exp(input int i, input logic [7:0] press);
        exp_t e;
        e.acertou = (press != 8'h00) && (press == rom[i]);
        e.to      = (press == 8'h00);
        e.leds    = e.acertou ? rom[i] : 8'hFF;
        if (press != 8'h00) exp_jog = press;
        e.jog     = exp_jog;
        if (e.acertou && exp_score < 4) exp_score++;
        e.score   = exp_score;
        e.esp     = (press == 8'h00) ? (cur_dif ? T_DIF : T_FAC) : 0;
        return e;
    endfunction

    task automatic start_game(input logic dif);
        @(negedge clock);
        plays = 0;
        dificuldade = dif;
        cur_dif = dif;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        exp_score = 0;
        exp_jog = 8'h00;
        chk("start_state", db_estado, 4'd1);
        chk("start_score", score, 0);
        chk("start_jogada", db_jogada, 8'h00);
    endtask

    task automatic do_play(input int i, input logic [7:0] press);
        wait_state(4'd3, 40);
        chk("mostra_leds", leds, rom[i]);
        chk("mostra_addr", bus.mem_endereco, i);
        sb.push_back(make_exp(i, press));
        wait_state(4'd4, 20);
        if (press != 8'h00) begin
            @(negedge clock);
            botoes = press;
        end
        wait_state(4'd7, 30);
        botoes = 8'h00;
    endtask

    task automatic finish_game(input int sc, input int np);
        wait_state(4'd9, 40);
        chk("fim_pronto", pronto, 1'b1);
        chk("fim_score", score, sc);
        chk("fim_leds", leds, 8'h00);
        chk("fim_acertou", acertou, 1'b0);
        chk("fim_plays", plays, np);
    endtask

    initial begin
        games[0].dif = 1'b1; games[0].rom = {8'h08, 8'h04, 8'h02, 8'h01};
        games[0].press = {8'h08, 8'h04, 8'h02, 8'h01}; games[0].exp_score = 4; games[0].exp_plays = 4;
        games[1].dif = 1'b0; games[1].rom = {8'h08, 8'h04, 8'h02, 8'h01};
        games[1].press = {8'h00, 8'h00, 8'h00, 8'h00}; games[1].exp_score = 0; games[1].exp_plays = 2;
        games[2].dif = 1'b1; games[2].rom = {8'h08, 8'h04, 8'h02, 8'h01};
        games[2].press = {8'h10, 8'h00, 8'h02, 8'h03}; games[2].exp_score = 1; games[2].exp_plays = 4;
        games[3].dif = 1'b0; games[3].rom = {8'h01, 8'h02, 8'h40, 8'h80};
        games[3].press = {8'h80, 8'h40, 8'h40, 8'h80}; games[3].exp_score = 2; games[3].exp_plays = 2;
        rom = games[0].rom;

        repeat (3) @(negedge clock);
        chk("rst_state", db_estado, 4'd0);
        chk("rst_leds", leds, 8'h00);
        chk("rst_score", score, 0);
        chk("rst_flags", {acertou, deu_timeout, pronto}, 3'b000);
        chk("rst_jogada", db_jogada, 8'h00);
        chk("rst_addr", bus.mem_endereco, 0);
        reset = 1'b0;

        for (int g = 0; g < 3; g++) begin
            rom = games[g].rom;
            start_game(games[g].dif);
            for (int i = 0; i < games[g].exp_plays; i++) do_play(i, games[g].press[i]);
            finish_game(games[g].exp_score, games[g].exp_plays);
        end

        // Button held from MOSTRA is ignored; re-press lands on the timeout cycle.
        rom = {8'h08, 8'h04, 8'h02, 8'h01};
        start_game(1'b1);
        wait_state(4'd3, 40);
        botoes = 8'h01;
        sb.push_back(make_exp(0, 8'h01));
        wait_state(4'd4, 20);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            chk("held_no_register", db_estado, 4'd4);
        end
        botoes = 8'h00;
        @(negedge clock);
        chk("release_still_wait", db_estado, 4'd4);
        botoes = 8'h01;
        @(negedge clock);
        chk("timeout_cycle_press", db_estado, 4'd5);
        wait_state(4'd7, 30);
        botoes = 8'h00;
        do_play(1, 8'h02);
        do_play(2, 8'h04);
        do_play(3, 8'h08);
        finish_game(4, 4);

        // Mid-game iniciar and dificuldade are ignored; reset in ESPERA of play 2.
        start_game(1'b1);
        do_play(0, 8'h01);
        wait_state(4'd3, 40);
        iniciar = 1'b1;
        dificuldade = 1'b0;
        @(negedge clock);
        iniciar = 1'b0;
        chk("iniciar_ignored", db_estado, 4'd3);
        do_play(1, 8'h02);
        wait_state(4'd3, 40);
        chk("play2_addr", bus.mem_endereco, 2);
        wait_state(4'd4, 20);
        chk("pre_reset_score", score, 2);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("post_reset_state", db_estado, 4'd0);
        chk("post_reset_score", score, 0);
        chk("post_reset_leds", leds, 8'h00);
        sb.delete();

        rom = games[3].rom;
        start_game(games[3].dif);
        for (int i = 0; i < games[3].exp_plays; i++) do_play(i, games[3].press[i]);
        finish_game(games[3].exp_score, games[3].exp_plays);

        repeat (4) @(negedge clock);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
